rps_classify_seq: RTL and testbench

//  Multi-cycle sequencer for the rock-paper-scissors classifier. It reads a binary image
//  one row per cycle from a row-addressed buffer and extracts four features: total pixels,

---
 rtl/rps_classify_seq_if.sv | 37 +++
 rtl/rps_classify_seq.sv | 208 ++++++++++++++++++++
 tb/tb_rps_classify_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rps_classify_seq_if.sv
// Start/result handshake, extracted features and row-buffer read port of the
// rock-paper-scissors classification sequencer.
interface rps_classify_seq_if #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 32,
    parameter int LEFT   = 8
);
    localparam int AW  = $clog2(LENGTH);
    localparam int SW  = $clog2(LENGTH * WIDTH + 1);
    localparam int SLW = $clog2(LENGTH * LEFT + 1);
    localparam int LMW = $clog2(WIDTH) + 1;

    logic             start;
    logic             busy;
    logic             row_rd;
    logic [AW-1:0]    row_addr;
    logic [WIDTH-1:0] row_data;
    logic             result_valid;
    logic             result_ack;
    logic [1:0]       result;
    logic [SW-1:0]    sum;
    logic [SLW-1:0]   sum_left;
    logic [LMW-1:0]   leftmost;
    logic [AW-1:0]    num_trans;

    modport slave (
        input  start, row_data, result_ack,
        output busy, row_rd, row_addr, result_valid, result,
               sum, sum_left, leftmost, num_trans
    );

    modport master (
        output start, row_data, result_ack,
        input  busy, row_rd, row_addr, result_valid, result,
               sum, sum_left, leftmost, num_trans
    );
endinterface

// File: rtl/rps_classify_seq.sv
// Two-pass row sequencer: pass 1 gathers pixel counts and the leftmost column,
// pass 2 counts row-to-row transitions at leftmost+SHIFT, then a class is issued.
module rps_classify_seq #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 32,
    parameter int LEFT   = 8,
    parameter int SHIFT  = 4
) (
    input logic              clk,
    input logic              rst,
    rps_classify_seq_if.slave bus
);
    localparam int AW     = $clog2(LENGTH);
    localparam int SW     = $clog2(LENGTH * WIDTH + 1);
    localparam int SLW    = $clog2(LENGTH * LEFT + 1);
    localparam int LMW    = $clog2(WIDTH) + 1;
    localparam int CW     = $clog2(WIDTH);
    localparam int PW     = $clog2(WIDTH + 1);
    localparam int CNTW   = $clog2(LENGTH + 1);
    localparam int THRESH = (LENGTH * WIDTH) / 50;

    localparam logic [LMW-1:0]   LM_NONE   = '1;
    localparam logic [WIDTH-1:0] LEFT_MASK = {{(WIDTH - LEFT){1'b0}}, {LEFT{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_PASS2,
        S_CLASSIFY,
        S_DONE
    } state_t;

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++) begin
            r = r + PW'(v[j]);
        end
        return r;
    endfunction

    // Lowest set column, or all-ones when the row is blank (never wins a min()).
    function automatic logic [LMW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [LMW-1:0] r;
        r = LM_NONE;
        for (int j = WIDTH - 1; j >= 0; j--) begin
            if (v[j]) begin
                r = LMW'(j);
            end
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (v == AW'(LENGTH - 1)) ? v : v + AW'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             row_rd_q, row_rd_d;
    logic [AW-1:0]    row_addr_q, row_addr_d;
    logic             dvld_q;
    logic [AW-1:0]    drow_q;
    logic             prev_q, prev_d;
    logic [1:0]       result_q, result_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [SLW-1:0]   sum_left_q, sum_left_d;
    logic [LMW-1:0]   leftmost_q, leftmost_d;
    logic [AW-1:0]    num_trans_q, num_trans_d;

    logic [PW-1:0]    row_pop;
    logic [PW-1:0]    left_pop;
    logic [LMW-1:0]   row_lm;
    logic [LMW:0]     col_sum;
    logic             col_ok;
    logic [CW-1:0]    col_idx;
    logic             col_bit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_rd_d    = 1'b0;
        row_addr_d  = row_addr_q;
        prev_d      = prev_q;
        result_d    = result_q;
        sum_d       = sum_q;
        sum_left_d  = sum_left_q;
        leftmost_d  = leftmost_q;
        num_trans_d = num_trans_q;

        row_pop  = popcount(bus.row_data);
        left_pop = popcount(bus.row_data & LEFT_MASK);
        row_lm   = lowest_set(bus.row_data);
        col_sum  = {1'b0, leftmost_q} + (LMW + 1)'(SHIFT);
        col_ok   = (leftmost_q != LM_NONE) && (col_sum < (LMW + 1)'(WIDTH));
        col_idx  = col_ok ? col_sum[CW-1:0] : '0;
        col_bit  = bus.row_data[col_idx];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_PASS1;
                    cnt_d       = '0;
                    row_rd_d    = 1'b1;
                    row_addr_d  = '0;
                    sum_d       = '0;
                    sum_left_d  = '0;
                    leftmost_d  = LM_NONE;
                    num_trans_d = '0;
                    prev_d      = 1'b0;
                end else if (state_q == S_DONE && bus.result_ack) begin
                    state_d = S_IDLE;
                end
            end

            S_PASS1, S_PASS2: begin
                // Row data lags its read strobe by one cycle; dvld_q/drow_q track it.
                if (dvld_q) begin
                    if (state_q == S_PASS1) begin
                        sum_d      = sum_q + SW'(row_pop);
                        sum_left_d = sum_left_q + SLW'(left_pop);
                        if (row_lm < leftmost_q) begin
                            leftmost_d = row_lm;
                        end
                    end else if (col_ok) begin
                        if (drow_q != '0 && col_bit != prev_q) begin
                            num_trans_d = sat_inc(num_trans_q);
                        end
                        prev_d = col_bit;
                    end
                end

                if (cnt_q == CNTW'(LENGTH)) begin
                    cnt_d = '0;
                    if (state_q == S_PASS1) begin
                        state_d    = S_PASS2;
                        row_rd_d   = 1'b1;
                        row_addr_d = '0;
                    end else begin
                        state_d = S_CLASSIFY;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q < CNTW'(LENGTH - 1)) begin
                        row_rd_d   = 1'b1;
                        row_addr_d = row_addr_q + AW'(1);
                    end
                end
            end

            S_CLASSIFY: begin
                state_d = S_DONE;
                if (num_trans_q == AW'(4)) begin
                    result_d = 2'b10;
                end else if (sum_left_q > SLW'(THRESH)) begin
                    result_d = 2'b01;
                end else begin
                    result_d = 2'b00;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_rd_q    <= 1'b0;
            row_addr_q  <= '0;
            dvld_q      <= 1'b0;
            drow_q      <= '0;
            prev_q      <= 1'b0;
            result_q    <= '0;
            sum_q       <= '0;
            sum_left_q  <= '0;
            leftmost_q  <= LM_NONE;
            num_trans_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_rd_q    <= row_rd_d;
            row_addr_q  <= row_addr_d;
            dvld_q      <= row_rd_q;
            drow_q      <= row_addr_q;
            prev_q      <= prev_d;
            result_q    <= result_d;
            sum_q       <= sum_d;
            sum_left_q  <= sum_left_d;
            leftmost_q  <= leftmost_d;
            num_trans_q <= num_trans_d;
        end
    end

    assign bus.busy         = (state_q == S_PASS1) || (state_q == S_PASS2) ||
                              (state_q == S_CLASSIFY);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.row_rd       = row_rd_q;
    assign bus.row_addr     = row_addr_q;
    assign bus.result       = result_q;
    assign bus.sum          = sum_q;
    assign bus.sum_left     = sum_left_q;
    assign bus.leftmost     = leftmost_q;
    assign bus.num_trans    = num_trans_q;
endmodule

// File: tb/tb_rps_classify_seq.sv
// Bench for rps_classify_seq: table vectors, handshake corner cases and random
// images checked against a feature-level reference model.
module tb_rps_classify_seq;
    localparam int LENGTH = 32;
    localparam int WIDTH  = 32;
    localparam int LEFT   = 8;
    localparam int SHIFT  = 4;
    localparam int LAT    = 2 * LENGTH + 4;
    localparam int NONE   = 63;

    logic clk;
    logic rst;
    logic [WIDTH-1:0] img [LENGTH];

    int total = 0;
    int bad   = 0;

    rps_classify_seq_if #(.LENGTH(LENGTH), .WIDTH(WIDTH), .LEFT(LEFT)) bif ();

    rps_classify_seq #(.LENGTH(LENGTH), .WIDTH(WIDTH), .LEFT(LEFT), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row buffer: registered read, garbage on non-read cycles.
    always @(posedge clk) begin
        if (bif.row_rd) bif.row_data <= img[bif.row_addr];
        else            bif.row_data <= WIDTH'($urandom);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int kind;
        int arg;
        int s;
        int sl;
        int lm;
        int nt;
        int res;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input int kind, input int arg);
        for (int r = 0; r < LENGTH; r++) begin
            img[r] = '0;
            case (kind)
                1: img[r] = WIDTH'(32'h0000_00FF);
                2: begin
                    if ((r >= 4 && r <= 7) || (r >= 12 && r <= 15)) img[r][14] = 1'b1;
                    if (r == 0) img[r][10] = 1'b1;
                end
                3: if (r % 2 == 0) img[r][30] = 1'b1;
                4: img[r] = '1;
                5: if (r % 2 == 0) img[r] = '1;
                6: if (r == LENGTH - 1) img[r][WIDTH-1] = 1'b1;
                7: if (r < arg) img[r][0] = 1'b1;
                8: begin
                    if (r == 0) img[r][0] = 1'b1;
                    if (r >= 2 && r <= 2 * arg && r % 2 == 0) img[r][4] = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic rand_image(input int style);
        int sh, c, per;
        sh  = $urandom_range(0, WIDTH - 1);
        c   = $urandom_range(0, WIDTH - 1);
        per = $urandom_range(1, 8);
        for (int r = 0; r < LENGTH; r++) begin
            case (style)
                0: img[r] = WIDTH'($urandom & $urandom & $urandom);
                1: img[r] = WIDTH'(($urandom & $urandom & $urandom & $urandom) << sh);
                default: begin
                    img[r] = '0;
                    if (((r / per) % 2) == 1) img[r][c] = 1'b1;
                    if (r == 0 && c >= SHIFT) img[r][c-SHIFT] = 1'b1;
                end
            endcase
        end
    endtask

    // Feature extraction straight from the image, then the class rule.
    task automatic model(output int s, output int sl, output int lm, output int nt,
                         output int res);
        int col;
        s = 0; sl = 0; lm = NONE; nt = 0;
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < WIDTH; c++)
                if (img[r][c]) begin
                    s++;
                    if (c < LEFT) sl++;
                    if (c < lm) lm = c;
                end
        col = lm + SHIFT;
        if (lm != NONE && col < WIDTH)
            for (int r = 1; r < LENGTH; r++)
                if (img[r][col] != img[r-1][col]) nt++;
        if (nt > LENGTH - 1) nt = LENGTH - 1;
        if (nt == 4) res = 2;
        else if (sl > (LENGTH * WIDTH) / 50) res = 1;
        else res = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " busy"},      int'(bif.busy), 0);
        chk({tag, " row_rd"},    int'(bif.row_rd), 0);
        chk({tag, " valid"},     int'(bif.result_valid), 0);
        chk({tag, " row_addr"},  int'(bif.row_addr), 0);
        chk({tag, " result"},    int'(bif.result), 0);
        chk({tag, " sum"},       int'(bif.sum), 0);
        chk({tag, " sum_left"},  int'(bif.sum_left), 0);
        chk({tag, " leftmost"},  int'(bif.leftmost), NONE);
        chk({tag, " num_trans"}, int'(bif.num_trans), 0);
    endtask

    // Starts a job at the next negedge and waits for result_valid.
    task automatic run_job(input string tag, input bit busy_start, input bit with_ack);
        int n;
        @(negedge clk);
        bif.start = 1'b1;
        if (with_ack) bif.result_ack = 1'b1;
        @(negedge clk);
        bif.start      = 1'b0;
        bif.result_ack = 1'b0;
        n = 1;
        chk({tag, " start_valid"}, int'(bif.result_valid), 0);
        chk({tag, " start_busy"},  int'(bif.busy), 1);
        chk({tag, " start_rd"},    int'(bif.row_rd), 1);
        chk({tag, " start_addr"},  int'(bif.row_addr), 0);
        while (bif.result_valid !== 1'b1 && n < 200) begin
            bif.start = (busy_start && (n == 10 || n == 40)) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        bif.start = 1'b0;
        chk({tag, " latency"}, n, LAT);
    endtask

    task automatic check_result(input string tag, input int s, input int sl, input int lm,
                                input int nt, input int res);
        chk({tag, " sum"},       int'(bif.sum), s);
        chk({tag, " sum_left"},  int'(bif.sum_left), sl);
        chk({tag, " leftmost"},  int'(bif.leftmost), lm);
        chk({tag, " num_trans"}, int'(bif.num_trans), nt);
        chk({tag, " result"},    int'(bif.result), res);
        chk({tag, " done_busy"}, int'(bif.busy), 0);
        repeat (3) @(negedge clk);
        chk({tag, " hold_valid"},  int'(bif.result_valid), 1);
        chk({tag, " hold_result"}, int'(bif.result), res);
    endtask

    task automatic ack_result(input string tag, input int res);
        bif.result_ack = 1'b1;
        @(negedge clk);
        bif.result_ack = 1'b0;
        chk({tag, " ack_valid"},  int'(bif.result_valid), 0);
        chk({tag, " ack_busy"},   int'(bif.busy), 0);
        chk({tag, " idle_result"}, int'(bif.result), res);
    endtask

    vec_t tbl [11];

    initial begin
        int s, sl, lm, nt, res;
        string tag;

        tbl[0]  = '{0, 0,    0,   0, NONE,  0, 0};
        tbl[1]  = '{1, 0,  256, 256,    0,  0, 1};
        tbl[2]  = '{2, 0,    9,   0,   10,  4, 2};
        tbl[3]  = '{3, 0,   16,   0,   30,  0, 0};
        tbl[4]  = '{4, 0, 1024, 256,    0,  0, 1};
        tbl[5]  = '{5, 0,  512, 128,    0, 31, 1};
        tbl[6]  = '{6, 0,    1,   0,   31,  0, 0};
        tbl[7]  = '{7, 20,  20,  20,    0,  0, 0};
        tbl[8]  = '{7, 21,  21,  21,    0,  0, 1};
        tbl[9]  = '{8, 2,    3,   3,    0,  4, 2};
        tbl[10] = '{8, 3,    4,   4,    0,  6, 0};

        rst = 1'b1;
        bif.start = 1'b0;
        bif.result_ack = 1'b0;
        build(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("vec%0d", i);
            build(tbl[i].kind, tbl[i].arg);
            run_job(tag, 1'b0, 1'b0);
            check_result(tag, tbl[i].s, tbl[i].sl, tbl[i].lm, tbl[i].nt, tbl[i].res);
            ack_result(tag, tbl[i].res);
        end

        // start while busy is ignored; then start+ack together restarts from DONE
        build(2, 0);
        run_job("busy_start", 1'b1, 1'b0);
        check_result("busy_start", 9, 0, 10, 4, 2);
        build(1, 0);
        run_job("start_ack", 1'b0, 1'b1);
        check_result("start_ack", 256, 256, 0, 0, 1);
        ack_result("start_ack", 1);

        // reset in the middle of the second pass
        build(4, 0);
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (48) @(negedge clk);
        chk("midrst pre_busy", int'(bif.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midrst");
        build(2, 0);
        run_job("after_rst", 1'b0, 1'b0);
        check_result("after_rst", 9, 0, 10, 4, 2);
        ack_result("after_rst", 2);

        for (int i = 0; i < 24; i++) begin
            tag = $sformatf("rand%0d", i);
            rand_image(i % 3);
            model(s, sl, lm, nt, res);
            run_job(tag, 1'b0, 1'b0);
            check_result(tag, s, sl, lm, nt, res);
            ack_result(tag, res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
